// File: rtl/conf_int_add__result_acc.sv
// -----------------------------------------------------------------------------
// conf_int_add__result_acc
//
// Consumes the result stream of the configurable-precision integer adder and
// produces one sum per block of N samples, so each adder configuration can be
// characterised for error/energy block by block.
//
// Each incoming sample c is masked to the precision selected by conf_select
// (conf_select = k in 0..3 clears the low 4*k bits; larger values mean full
// precision). The first sample of a block latches N (blk_len, 0 read as 1) and
// the configuration; later changes to conf_select/blk_len inside the block are
// ignored. The finished sum is held until downstream takes it.
//
// Optional feature (compile-time macro):
//   CONF_INT_ADD__ACC_SAT_EN  - defined: a carry out of the accumulator
//                               saturates acc_out to all-ones for the rest of
//                               the block. Undefined (default): the sum wraps
//                               modulo 2^ACC_W. ovf is set in both cases.
//
// Ports:
//   clk          in   1                   clock, rising edge
//   rst          in   1                   asynchronous reset, active-low
//   flush        in   1                   synchronous abort of the current block
//   c            in   DATA_PATH_BITWIDTH  adder result sample
//   conf_select  in   CONF_SELECT__C_B    precision config of incoming samples
//   blk_len      in   BLK_LEN_B           samples per block (0 treated as 1)
//   in_valid     in   1                   c/conf_select valid
//   in_ready     out  1                   block can accept a sample
//   acc_out      out  ACC_W               block sum, stable while out_valid
//   conf_out     out  CONF_SELECT__C_B    conf_select latched for this block
//   ovf          out  1                   sticky carry out of the block sum
//   out_valid    out  1                   block result available
//   out_ready    in   1                   downstream accepts the result
// -----------------------------------------------------------------------------
module conf_int_add__result_acc #(
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int CONF_SELECT__C_B   = 4,
   parameter int ACC_GUARD_B        = 8,
   parameter int BLK_LEN_B          = 4,
   localparam int ACC_W             = DATA_PATH_BITWIDTH + ACC_GUARD_B
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [DATA_PATH_BITWIDTH-1:0] c,
   input  logic [CONF_SELECT__C_B-1:0]   conf_select,
   input  logic [BLK_LEN_B-1:0]          blk_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [ACC_W-1:0]              acc_out,
   output logic [CONF_SELECT__C_B-1:0]   conf_out,
   output logic                          ovf,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [BLK_LEN_B-1:0] CNT_ONE = {{(BLK_LEN_B-1){1'b0}}, 1'b1};

   // Clear the low 4*k bits of a sample; k above 3 keeps full precision.
   function automatic logic [DATA_PATH_BITWIDTH-1:0] mask_sample(
      input logic [DATA_PATH_BITWIDTH-1:0] smp,
      input logic [CONF_SELECT__C_B-1:0]   k
   );
      logic [DATA_PATH_BITWIDTH-1:0] keep;
      int unsigned                   ki;
      ki   = 32'(k);
      keep = '1;
      if (ki < 32'd4) begin
         keep = keep << (4 * ki);
      end
      return smp & keep;
   endfunction

   // Unsigned add with the carry kept in the extra top bit.
   function automatic logic [ACC_W:0] acc_add(
      input logic [ACC_W-1:0]              a,
      input logic [DATA_PATH_BITWIDTH-1:0] b
   );
      logic [ACC_W:0] b_ext;
      b_ext = '0;
      b_ext[DATA_PATH_BITWIDTH-1:0] = b;
      return {1'b0, a} + b_ext;
   endfunction

   // Overflow handling of a carried sum. Once saturated, every later add
   // either carries again or adds zero, so all-ones persists to block end.
   function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] sum);
`ifdef CONF_INT_ADD__ACC_SAT_EN
      if (sum[ACC_W]) begin
         return '1;
      end
      return sum[ACC_W-1:0];
`else
      return sum[ACC_W-1:0];
`endif
   endfunction

   logic [1:0]                    state;
   logic [BLK_LEN_B-1:0]          blk_n;
   logic [BLK_LEN_B-1:0]          count;
   logic [BLK_LEN_B-1:0]          count_inc;
   logic [BLK_LEN_B-1:0]          blk_eff;
   logic [DATA_PATH_BITWIDTH-1:0] masked_first;
   logic [DATA_PATH_BITWIDTH-1:0] masked_blk;
   logic [ACC_W-1:0]              first_ext;
   logic [ACC_W:0]                sum;

   assign in_ready  = (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);

   always_comb begin
      blk_eff = blk_len;
      if (blk_len == '0) begin
         blk_eff[0] = 1'b1;
      end
      count_inc = count + 1'b1;
      // First sample of a block uses the live config; the rest use the latched one.
      masked_first = mask_sample(c, conf_select);
      masked_blk   = mask_sample(c, conf_out);
      first_ext    = '0;
      first_ext[DATA_PATH_BITWIDTH-1:0] = masked_first;
      sum = acc_add(acc_out, masked_blk);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         acc_out  <= '0;
         conf_out <= '0;
         ovf      <= 1'b0;
         count    <= '0;
         blk_n    <= '0;
      end else if (flush) begin
         // Abort wins over any sample or result handshake this cycle.
         state   <= ST_IDLE;
         acc_out <= '0;
         count   <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  blk_n    <= blk_eff;
                  conf_out <= conf_select;
                  acc_out  <= first_ext;
                  count    <= CNT_ONE;
                  ovf      <= 1'b0;
                  state    <= (blk_eff == CNT_ONE) ? ST_HOLD : ST_ACC;
               end
            end
            ST_ACC: begin
               if (in_valid) begin
                  acc_out <= acc_limit(sum);
                  ovf     <= ovf | sum[ACC_W];
                  count   <= count_inc;
                  if (count_inc == blk_n) begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conf_int_add__result_acc.sv
// -----------------------------------------------------------------------------
// tb_conf_int_add__result_acc
//
// Directed-vector bench for conf_int_add__result_acc. One instance uses the
// default parameters (ACC_W = 24); a second instance with ACC_GUARD_B = 0
// (ACC_W = 16) exercises the accumulator carry-out.
// -----------------------------------------------------------------------------
module tb_conf_int_add__result_acc;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] c;
   logic [3:0]  conf_select;
   logic [3:0]  blk_len;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] acc_out;
   logic [3:0]  conf_out;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   logic        flush0;
   logic [15:0] c0;
   logic [3:0]  conf_select0;
   logic [3:0]  blk_len0;
   logic        in_valid0;
   logic        in_ready0;
   logic [15:0] acc_out0;
   logic [3:0]  conf_out0;
   logic        ovf0;
   logic        out_valid0;
   logic        out_ready0;

   int n_total;
   int n_bad;

   conf_int_add__result_acc u_dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .c           (c),
      .conf_select (conf_select),
      .blk_len     (blk_len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .acc_out     (acc_out),
      .conf_out    (conf_out),
      .ovf         (ovf),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   conf_int_add__result_acc #(.ACC_GUARD_B(0)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush0),
      .c           (c0),
      .conf_select (conf_select0),
      .blk_len     (blk_len0),
      .in_valid    (in_valid0),
      .in_ready    (in_ready0),
      .acc_out     (acc_out0),
      .conf_out    (conf_out0),
      .ovf         (ovf0),
      .out_valid   (out_valid0),
      .out_ready   (out_ready0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] cv, input logic [3:0] k, input logic [3:0] n);
      c           = cv;
      conf_select = k;
      blk_len     = n;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
   endtask

   task automatic send0(input logic [15:0] cv, input logic [3:0] n);
      c0           = cv;
      conf_select0 = 4'd0;
      blk_len0     = n;
      in_valid0    = 1'b1;
      tick();
      in_valid0    = 1'b0;
   endtask

   initial begin
      n_total      = 0;
      n_bad        = 0;
      rst          = 1'b0;
      flush        = 1'b0;
      c            = '0;
      conf_select  = '0;
      blk_len      = '0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      flush0       = 1'b0;
      c0           = '0;
      conf_select0 = '0;
      blk_len0     = '0;
      in_valid0    = 1'b0;
      out_ready0   = 1'b0;

      // reset values
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_acc", 32'(acc_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_conf_out", 32'(conf_out), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b1;
      tick();

      // 1: reset in the middle of a block
      send(16'd5, 4'd0, 4'd4);
      send(16'd6, 4'd0, 4'd4);
      chk("t1_acc_mid", 32'(acc_out), 32'd11);
      chk("t1_in_ready_mid", 32'(in_ready), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t1_acc_async", 32'(acc_out), 32'd0);
      chk("t1_out_valid_async", 32'(out_valid), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("t1_in_ready_rel", 32'(in_ready), 32'd1);
      chk("t1_out_valid_rel", 32'(out_valid), 32'd0);
      chk("t1_ovf_rel", 32'(ovf), 32'd0);
      chk("t1_acc_rel", 32'(acc_out), 32'd0);

      // 2: N=4 full precision, out_ready held high
      out_ready = 1'b1;
      send(16'd1, 4'd0, 4'd4);
      send(16'd2, 4'd0, 4'd4);
      send(16'd3, 4'd0, 4'd4);
      chk("t2_no_valid_early", 32'(out_valid), 32'd0);
      send(16'd4, 4'd0, 4'd4);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_acc", 32'(acc_out), 32'd10);
      chk("t2_conf_out", 32'(conf_out), 32'd0);
      chk("t2_in_ready_hold", 32'(in_ready), 32'd0);
      tick();
      chk("t2_valid_drop", 32'(out_valid), 32'd0);
      chk("t2_in_ready_idle", 32'(in_ready), 32'd1);
      out_ready = 1'b0;

      // 3: conf=2 masking, later conf/blk_len changes ignored
      send(16'h00FF, 4'd2, 4'd2);
      send(16'h0123, 4'd0, 4'd7);
      chk("t3_acc", 32'(acc_out), 32'h100);
      chk("t3_conf_out", 32'(conf_out), 32'd2);
      chk("t3_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // conf=3 masks the low 12 bits: A000 + 1000 + F000
      send(16'hABCD, 4'd3, 4'd3);
      send(16'h1FFF, 4'd0, 4'd0);
      send(16'hF000, 4'd1, 4'd1);
      chk("t3b_acc", 32'(acc_out), 32'h1A000);
      chk("t3b_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // conf=5 is treated as full precision
      send(16'h000F, 4'd5, 4'd2);
      send(16'h0001, 4'd5, 4'd2);
      chk("t3c_acc", 32'(acc_out), 32'h10);
      chk("t3c_conf_out", 32'(conf_out), 32'd5);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 4: blk_len=0 acts as N=1; result held while out_ready is low
      send(16'd7, 4'd0, 4'd0);
      chk("t4_acc", 32'(acc_out), 32'd7);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      c        = 16'd99;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
         chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_acc", 32'(acc_out), 32'd7);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_release_valid", 32'(out_valid), 32'd0);
      chk("t4_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("t4_idle_valid", 32'(out_valid), 32'd0);

      // 5: carry out of a 16-bit accumulator
      send0(16'hFFFF, 4'd2);
      chk("t5_acc_first", 32'(acc_out0), 32'hFFFF);
      chk("t5_ovf_first", 32'(ovf0), 32'd0);
      send0(16'hFFFF, 4'd2);
      chk("t5_ovf", 32'(ovf0), 32'd1);
      chk("t5_out_valid", 32'(out_valid0), 32'd1);
`ifdef CONF_INT_ADD__ACC_SAT_EN
      chk("t5_acc", 32'(acc_out0), 32'hFFFF);
`else
      chk("t5_acc", 32'(acc_out0), 32'hFFFE);
`endif
      out_ready0 = 1'b1;
      tick();
      out_ready0 = 1'b0;
      send0(16'hFFFF, 4'd3);
      chk("t5b_ovf_clear", 32'(ovf0), 32'd0);
      send0(16'hFFFF, 4'd3);
      send0(16'h0002, 4'd3);
      chk("t5b_ovf_sticky", 32'(ovf0), 32'd1);
`ifdef CONF_INT_ADD__ACC_SAT_EN
      chk("t5b_acc", 32'(acc_out0), 32'hFFFF);
`else
      chk("t5b_acc", 32'(acc_out0), 32'h0000);
`endif
      out_ready0 = 1'b1;
      tick();
      out_ready0 = 1'b0;

      // 6: flush during ACC with a sample offered, and during HOLD with out_ready
      send(16'd5, 4'd0, 4'd3);
      chk("t6_acc_pre", 32'(acc_out), 32'd5);
      c        = 16'd9;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t6_acc_flush", 32'(acc_out), 32'd0);
      chk("t6_valid_flush", 32'(out_valid), 32'd0);
      chk("t6_in_ready_flush", 32'(in_ready), 32'd1);
      send(16'd3, 4'd0, 4'd1);
      chk("t6_new_block_acc", 32'(acc_out), 32'd3);
      chk("t6_new_block_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      chk("t6_hold_flush_valid", 32'(out_valid), 32'd0);
      chk("t6_hold_flush_acc", 32'(acc_out), 32'd0);
      chk("t6_hold_flush_in_ready", 32'(in_ready), 32'd1);
      send(16'd1, 4'd0, 4'd2);
      chk("t6_after_first_valid", 32'(out_valid), 32'd0);
      send(16'd2, 4'd0, 4'd2);
      chk("t6_after_acc", 32'(acc_out), 32'd3);
      chk("t6_after_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
